// File: rtl/down_counter.sv
// Loadable down counter with one-cycle borrow-out pulse and IDLE/RUN sequencing FSM.
// Define AUTO_RELOAD_EN to restart from the last loaded value on each terminal edge.
module down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             count_enable,
    output logic [WIDTH-1:0] count,
    output logic             bo,
    output logic             busy
);

    // state | meaning
    // IDLE  | no count active; count_enable ignored, waiting for load
    // RUN   | draining count one step per enabled edge
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] count_next;
    logic             bo_next;

`ifdef AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reload <= '0;
        end else if (load) begin
            reload <= load_value;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            bo    <= 1'b0;
        end else begin
            state <= state_next;
            count <= count_next;
            bo    <= bo_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        bo_next    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    count_next = load_value;
                    state_next = RUN;
                end
            end
            RUN: begin
                // A load wins over a coincident terminal decrement.
                if (load) begin
                    count_next = load_value;
                end else if (count_enable) begin
                    if (count == '0) begin
                        bo_next = 1'b1;
`ifdef AUTO_RELOAD_EN
                        count_next = reload;
`else
                        state_next = IDLE;
`endif
                    end else begin
                        count_next = count - WIDTH'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: a behavioural model pushes the expected
// {count, bo, busy} per driven cycle; the sampled DUT outputs are popped and compared.
module tb_down_counter;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] load_value;
    logic         count_enable;
    logic [W-1:0] count;
    logic         bo;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_count;
    logic [W-1:0] m_reload;
    logic         m_bo;
    logic         m_busy;

    typedef struct packed {
        logic [W-1:0] count;
        logic         bo;
        logic         busy;
    } exp_t;

    exp_t exp_q[$];
    int   bo_seen;

    down_counter #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .load_value   (load_value),
        .count_enable (count_enable),
        .count        (count),
        .bo           (bo),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_count  = '0;
        m_reload = '0;
        m_bo     = 1'b0;
        m_busy   = 1'b0;
        exp_q.delete();
    endtask

    // Drive one cycle at the falling edge, predict, then compare after the rising edge.
    task automatic step(input string tag, input logic ld, input logic [W-1:0] lv, input logic ce);
        exp_t e, got;
        @(negedge clk);
        load         = ld;
        load_value   = lv;
        count_enable = ce;
        if (ld) begin
            m_count  = lv;
            m_reload = lv;
            m_busy   = 1'b1;
            m_bo     = 1'b0;
        end else if (m_busy && ce) begin
            if (m_count == '0) begin
                m_bo = 1'b1;
`ifdef AUTO_RELOAD_EN
                m_count = m_reload;
`else
                m_busy = 1'b0;
`endif
            end else begin
                m_count = m_count - 3'd1;
                m_bo    = 1'b0;
            end
        end else begin
            m_bo = 1'b0;
        end
        e.count = m_count;
        e.bo    = m_bo;
        e.busy  = m_busy;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (bo === 1'b1) bo_seen++;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 0, 1);
        end else begin
            got = exp_q.pop_front();
            check({tag, "_count"}, int'(count), int'(got.count));
            check({tag, "_bo"},    int'(bo),    int'(got.bo));
            check({tag, "_busy"},  int'(busy),  int'(got.busy));
        end
        load         = 1'b0;
        count_enable = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        load         = 1'b0;
        load_value   = '0;
        count_enable = 1'b0;
        model_reset();
        #2;
        check("reset_count", int'(count), 0);
        check("reset_bo",    int'(bo),    0);
        check("reset_busy",  int'(busy),  0);
        @(negedge clk);
        rst = 1'b0;

        // 1: count_enable alone in IDLE is ignored
        for (int i = 0; i < 5; i++) step("t1_idle_ce", 1'b0, 3'd0, 1'b1);

        // 2: load 5 and drain continuously
        step("t2_load", 1'b1, 3'd5, 1'b0);
        bo_seen = 0;
        for (int i = 0; i < 8; i++) step("t2_drain", 1'b0, 3'd0, 1'b1);
        check("t2_bo_pulses", bo_seen, 1);

        // 3: load 3, enable toggling
        step("t3_load", 1'b1, 3'd3, 1'b0);
        bo_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step("t3_en",  1'b0, 3'd0, 1'b1);
            step("t3_dis", 1'b0, 3'd0, 1'b0);
        end
        check("t3_bo_pulses", bo_seen, 1);

        // 4: terminal coincident with load is discarded; load 0 terminates on next enabled edge
        step("t4_load", 1'b1, 3'd1, 1'b0);
        step("t4_dec",  1'b0, 3'd0, 1'b1);
        bo_seen = 0;
        step("t4_collide", 1'b1, 3'd6, 1'b1);
        check("t4_no_bo", bo_seen, 0);
        step("t4_load0", 1'b1, 3'd0, 1'b0);
        step("t4_term0", 1'b0, 3'd0, 1'b1);
        step("t4_after", 1'b0, 3'd0, 1'b1);

        // 5: async reset mid-RUN
        step("t5_load", 1'b1, 3'd4, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_count", int'(count), 0);
        check("t5_rst_busy",  int'(busy),  0);
        check("t5_rst_bo",    int'(bo),    0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step("t5_reload", 1'b1, 3'd1, 1'b0);
        bo_seen = 0;
        for (int i = 0; i < 3; i++) step("t5_drain", 1'b0, 3'd0, 1'b1);
        check("t5_bo_pulses", bo_seen, 1);

        // 6: periodic operation (only meaningful with auto-reload); full-scale load otherwise
        step("t6_load", 1'b1, 3'd2, 1'b0);
        bo_seen = 0;
        for (int i = 0; i < 9; i++) step("t6_run", 1'b0, 3'd0, 1'b1);
`ifdef AUTO_RELOAD_EN
        check("t6_bo_pulses", bo_seen, 3);
`else
        check("t6_bo_pulses", bo_seen, 1);
`endif
        step("t6_max", 1'b1, 3'd7, 1'b0);
        for (int i = 0; i < 9; i++) step("t6_max_run", 1'b0, 3'd0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
